// File: rtl/cnt_sched_if.sv
// Request/grant bundle between requesting engines and the shared-counter scheduler.
// The master side drives requests and window lengths; the slave side returns grant, done and count.
interface cnt_sched_if #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned CNT_WIDTH = 7
);
  logic [NREQ-1:0]           req_i;
  logic [NREQ*CNT_WIDTH-1:0] len_i;
  logic [NREQ-1:0]           gnt_o;
  logic [NREQ-1:0]           done_o;
  logic                      busy_o;
  logic [CNT_WIDTH-1:0]      cnt_o;

  modport master (
    output req_i,
    output len_i,
    input  gnt_o,
    input  done_o,
    input  busy_o,
    input  cnt_o
  );

  modport slave (
    input  req_i,
    input  len_i,
    output gnt_o,
    output done_o,
    output busy_o,
    output cnt_o
  );
endinterface

// File: rtl/cnt_sched.sv
// Round-robin scheduler time-sharing one cycle counter among NREQ requesters.
// Optional macro CNT_SCHED_PRIO0_EN: requester 0 always wins arbitration and never moves ptr.
module cnt_sched #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned CNT_WIDTH = 7
) (
  input logic        clk,
  input logic        rst,
  cnt_sched_if.slave bus
);
  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e               state_q, state_d;
  logic [IdxW-1:0]      ptr_q, ptr_d;
  logic [IdxW-1:0]      owner_q, owner_d;
  logic [CNT_WIDTH-1:0] len_q, len_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [NREQ-1:0]      gnt_q, gnt_d;
  logic [NREQ-1:0]      done_q, done_d;

  logic [IdxW-1:0]      sel;
  logic [IdxW-1:0]      idx;
  logic                 req_any;
  logic [IdxW-1:0]      owner_inc;
  logic [IdxW-1:0]      next_ptr;
  logic [CNT_WIDTH-1:0] len_m1;
  logic [NREQ-1:0]      one;

  assign one = {{(NREQ-1){1'b0}}, 1'b1};

  // First set request searching upward from ptr, wrapping at NREQ.
  always_comb begin
    sel     = '0;
    req_any = 1'b0;
    idx     = ptr_q;
`ifdef CNT_SCHED_PRIO0_EN
    if (bus.req_i[0]) begin
      req_any = 1'b1;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!req_any && (idx != '0) && bus.req_i[idx]) begin
          sel     = idx;
          req_any = 1'b1;
        end
        idx = (idx == IdxW'(NREQ - 1)) ? '0 : idx + 1'b1;
      end
    end
`else
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!req_any && bus.req_i[idx]) begin
        sel     = idx;
        req_any = 1'b1;
      end
      idx = (idx == IdxW'(NREQ - 1)) ? '0 : idx + 1'b1;
    end
`endif
  end

  assign owner_inc = (owner_q == IdxW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
`ifdef CNT_SCHED_PRIO0_EN
  assign next_ptr  = (owner_q == '0) ? ptr_q : owner_inc;
`else
  assign next_ptr  = owner_inc;
`endif

  // Wrap arithmetic: len_q == 0 yields an all-ones terminal count.
  assign len_m1 = len_q - CNT_WIDTH'(1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    unique case (state_q)
      StIdle: begin
        gnt_d = '0;
        cnt_d = '0;
        if (req_any) begin
          state_d = StRun;
          gnt_d   = one << sel;
          owner_d = sel;
          len_d   = bus.len_i[sel*CNT_WIDTH +: CNT_WIDTH];
        end
      end
      StRun: begin
        if (!bus.req_i[owner_q]) begin
          // Abort wins over a coincident terminal count.
          state_d = StIdle;
          gnt_d   = '0;
          cnt_d   = '0;
          ptr_d   = next_ptr;
        end else if (cnt_q == len_m1) begin
          state_d = StDone;
          done_d  = one << owner_q;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
        gnt_d   = '0;
        cnt_d   = '0;
        ptr_d   = next_ptr;
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      owner_q <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
    end
  end

  assign bus.gnt_o  = gnt_q;
  assign bus.done_o = done_q;
  assign bus.busy_o = (state_q != StIdle);
  assign bus.cnt_o  = cnt_q;
endmodule

// File: tb/tb_cnt_sched.sv
// Directed self-checking bench for cnt_sched with hand-computed expectations.
module tb_cnt_sched;
  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 7;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cnt_sched_if #(.NREQ(NREQ), .CNT_WIDTH(W)) bus ();

  cnt_sched #(.NREQ(NREQ), .CNT_WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_len(input int unsigned k, input logic [W-1:0] v);
    bus.len_i[k*W +: W] = v;
  endtask

  task automatic check_all(input string tag, input logic [31:0] gnt, input logic [31:0] done,
                           input logic [31:0] busy, input logic [31:0] cnt);
    check({tag, ".gnt"}, 32'(bus.gnt_o), gnt);
    check({tag, ".done"}, 32'(bus.done_o), done);
    check({tag, ".busy"}, 32'(bus.busy_o), busy);
    check({tag, ".cnt"}, 32'(bus.cnt_o), cnt);
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    bus.req_i  = '0;
    tick();
    tick();
    rst        = 1'b0;
  endtask

  int unsigned exp_k;

  initial begin
    rst       = 1'b1;
    bus.req_i = '0;
    bus.len_i = '0;
    tick();
    tick();
    check_all("reset", 0, 0, 0, 0);

    // Single request, len 5
    do_reset();
    set_len(0, 7'd5);
    bus.req_i = 4'b0001;
    tick();
    check_all("single.grant", 32'h1, 0, 1, 0);
    for (int c = 1; c <= 4; c++) begin
      tick();
      check("single.cnt", 32'(bus.cnt_o), 32'(c));
      check("single.nodone", 32'(bus.done_o), 0);
    end
    tick();
    check_all("single.done", 32'h1, 32'h1, 1, 4);
    bus.req_i = '0;
    tick();
    check_all("single.idle", 0, 0, 0, 0);

    // Round-robin rotation, len 2 each, period 4
    do_reset();
    for (int unsigned k = 0; k < NREQ; k++) set_len(k, 7'd2);
`ifdef CNT_SCHED_PRIO0_EN
    bus.req_i = 4'b1110;
`else
    bus.req_i = 4'b1111;
`endif
    tick();
    for (int unsigned k = 0; k < 5; k++) begin
`ifdef CNT_SCHED_PRIO0_EN
      exp_k = 1 + (k % 3);
`else
      exp_k = k % 4;
`endif
      check("rr.gnt", 32'(bus.gnt_o), 32'(1) << exp_k);
      tick();
      tick();
      check("rr.done", 32'(bus.done_o), 32'(1) << exp_k);
      tick();
      check("rr.gap", 32'(bus.gnt_o), 0);
      tick();
    end

    // Zero length wraps to a 128-cycle window
    do_reset();
    set_len(2, 7'd0);
    bus.req_i = 4'b0100;
    tick();
    check_all("wrap.grant", 32'h4, 0, 1, 0);
    for (int c = 0; c < 127; c++) tick();
    check_all("wrap.last", 32'h4, 0, 1, 127);
    tick();
    check_all("wrap.done", 32'h4, 32'h4, 1, 127);
    bus.req_i = '0;
    tick();
    check_all("wrap.idle", 0, 0, 0, 0);

    // Abort of requester 1 at cnt 3
    do_reset();
    set_len(0, 7'd2);
    set_len(1, 7'd10);
    set_len(3, 7'd2);
    bus.req_i = 4'b0010;
    tick();
    check("abort.grant", 32'(bus.gnt_o), 32'h2);
    tick();
    tick();
    tick();
    check("abort.cnt", 32'(bus.cnt_o), 3);
    bus.req_i = 4'b1001;
    tick();
    check_all("abort.idle", 0, 0, 0, 0);
    tick();
`ifdef CNT_SCHED_PRIO0_EN
    check("abort.next", 32'(bus.gnt_o), 32'h1);
`else
    check("abort.next", 32'(bus.gnt_o), 32'h8);
`endif
    bus.req_i = '0;
    tick();

    // Async reset mid-window after ptr has moved to 2
    do_reset();
    set_len(1, 7'd1);
    set_len(2, 7'd20);
    bus.req_i = 4'b0010;
    tick();
    check("rst.pre_gnt", 32'(bus.gnt_o), 32'h2);
    tick();
    check("rst.pre_done", 32'(bus.done_o), 32'h2);
    bus.req_i = 4'b0100;
    tick();
    tick();
    check("rst.gnt", 32'(bus.gnt_o), 32'h4);
    for (int c = 0; c < 6; c++) tick();
    check("rst.cnt6", 32'(bus.cnt_o), 6);
    #2;
    rst = 1'b1;
    #1;
    check_all("rst.async", 0, 0, 0, 0);
    set_len(3, 7'd3);
    bus.req_i = 4'b1010;
    tick();
    check("rst.held", 32'(bus.busy_o), 0);
    rst = 1'b0;
    tick();
    check("rst.ptr0", 32'(bus.gnt_o), 32'h2);
    bus.req_i = '0;
    tick();

    // All requesting with len 1, period 3
    do_reset();
    for (int unsigned k = 0; k < NREQ; k++) set_len(k, 7'd1);
    bus.req_i = 4'b1111;
    tick();
    for (int unsigned k = 0; k < 6; k++) begin
`ifdef CNT_SCHED_PRIO0_EN
      exp_k = 0;
`else
      exp_k = k % 4;
`endif
      check("len1.gnt", 32'(bus.gnt_o), 32'(1) << exp_k);
      check("len1.cnt", 32'(bus.cnt_o), 0);
      tick();
      check("len1.done", 32'(bus.done_o), 32'(1) << exp_k);
      tick();
      check("len1.busy", 32'(bus.busy_o), 0);
      tick();
    end
    bus.req_i = '0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
